apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_pkg.sv | 16 +
 rtl/apb_master_if.sv | 43 ++++
 rtl/apb_decode.sv | 27 ++
 rtl/apb_master.sv | 123 ++++++++++++
 tb/tb_apb_master.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM states, bus widths and the slave-select address bit.
// Latency: none, compile-time constants only.
// Backpressure: not applicable.
package apb_pkg;

  localparam int APB_ADDR_W  = 8;
  localparam int APB_DATA_W  = 8;
  localparam int APB_SEL_BIT = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

endpackage

// File: rtl/apb_master_if.sv
// Bundle of the host request/response signals and the two-slave APB bus.
// Latency: none, wires only.
// Backpressure: host side is throttled by host_ready, APB side by PREADY1/PREADY2.
interface apb_master_if;
  import apb_pkg::*;

  logic                  host_req;
  logic                  host_write;
  logic [APB_ADDR_W-1:0] host_addr;
  logic [APB_DATA_W-1:0] host_wdata;
  logic                  host_ready;
  logic                  host_done;
  logic                  host_err;
  logic [APB_DATA_W-1:0] host_rdata;

  logic                  PSEL1;
  logic                  PSEL2;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [APB_ADDR_W-1:0] PADDR;
  logic [APB_DATA_W-1:0] PWDATA;
  logic [APB_DATA_W-1:0] PRDATA1;
  logic [APB_DATA_W-1:0] PRDATA2;
  logic                  PREADY1;
  logic                  PREADY2;

  // View of the APB master block itself.
  modport master (
    input  host_req, host_write, host_addr, host_wdata,
    output host_ready, host_done, host_err, host_rdata,
    output PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA1, PRDATA2, PREADY1, PREADY2
  );

  // View of the surrounding host plus slaves.
  modport slave (
    output host_req, host_write, host_addr, host_wdata,
    input  host_ready, host_done, host_err, host_rdata,
    input  PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA1, PRDATA2, PREADY1, PREADY2
  );

endinterface

// File: rtl/apb_decode.sv
// Slave decode from the select address bit plus PRDATA/PREADY return mux.
// Latency: purely combinational.
// Backpressure: forwards only the selected slave's PREADY; the other slave is ignored.
module apb_decode
  import apb_pkg::*;
(
  input  logic                  sel_en,
  input  logic                  sel_hi,
  input  logic [APB_DATA_W-1:0] prdata1,
  input  logic [APB_DATA_W-1:0] prdata2,
  input  logic                  pready1,
  input  logic                  pready2,
  output logic                  psel1,
  output logic                  psel2,
  output logic [APB_DATA_W-1:0] rdata,
  output logic                  ready
);

  // Exactly one select while a transfer is in flight, none otherwise.
  assign psel1 = sel_en & ~sel_hi;
  assign psel2 = sel_en &  sel_hi;

  // Return path follows the same address bit as the select.
  assign rdata = sel_hi ? prdata2 : prdata1;
  assign ready = sel_hi ? pready2 : pready1;

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master bridging a simple host request port to two slaves.
// Latency: accept at edge N, SETUP N+1, ACCESS N+2, host_done N+3 with no wait states.
// Backpressure: host_ready low during SETUP and waiting ACCESS; aborts after TIMEOUT ACCESS cycles.
module apb_master
  import apb_pkg::*;
#(
  parameter int TIMEOUT = 16
)
(
  input  logic         PCLK,
  input  logic         PRESETn,
  apb_master_if.master bus
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  apb_state_t            state;
  logic                  busy;
  logic                  penable;
  logic                  pwrite;
  logic [APB_ADDR_W-1:0] paddr;
  logic [APB_DATA_W-1:0] pwdata;
  logic [APB_DATA_W-1:0] rdata;
  logic                  done;
  logic                  err;
  logic [CNT_W-1:0]      wait_cnt;

  logic                  psel1;
  logic                  psel2;
  logic                  sel_ready;
  logic [APB_DATA_W-1:0] sel_rdata;
  logic                  timeout;
  logic                  host_ready;
  logic                  accept;

  apb_decode u_decode (
    .sel_en  (busy),
    .sel_hi  (paddr[APB_SEL_BIT]),
    .prdata1 (bus.PRDATA1),
    .prdata2 (bus.PRDATA2),
    .pready1 (bus.PREADY1),
    .pready2 (bus.PREADY2),
    .psel1   (psel1),
    .psel2   (psel2),
    .rdata   (sel_rdata),
    .ready   (sel_ready)
  );

  // Last allowed ACCESS cycle with the slave still not ready; a late PREADY in it still wins.
  assign timeout    = (state == ACCESS) & ~sel_ready & (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign host_ready = (state == IDLE) | ((state == ACCESS) & sel_ready & ~timeout);
  assign accept     = bus.host_req & host_ready;

  assign bus.host_ready = host_ready;
  assign bus.host_done  = done;
  assign bus.host_err   = err;
  assign bus.host_rdata = rdata;
  assign bus.PSEL1      = psel1;
  assign bus.PSEL2      = psel2;
  assign bus.PENABLE    = penable;
  assign bus.PWRITE     = pwrite;
  assign bus.PADDR      = paddr;
  assign bus.PWDATA     = pwdata;

  // Transfer FSM; an accepted request overrides the completion path so back-to-back goes straight to SETUP.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state    <= IDLE;
      busy     <= 1'b0;
      penable  <= 1'b0;
      pwrite   <= 1'b0;
      paddr    <= '0;
      pwdata   <= '0;
      rdata    <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      wait_cnt <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end
        ACCESS: begin
          if (sel_ready) begin
            done <= 1'b1;
            if (!pwrite) rdata <= sel_rdata;
            state   <= IDLE;
            busy    <= 1'b0;
            penable <= 1'b0;
          end else if (timeout) begin
            done    <= 1'b1;
            err     <= 1'b1;
            state   <= IDLE;
            busy    <= 1'b0;
            penable <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          penable <= 1'b0;
        end
      endcase
      if (accept) begin
        paddr    <= bus.host_addr;
        pwrite   <= bus.host_write;
        pwdata   <= bus.host_wdata;
        state    <= SETUP;
        busy     <= 1'b1;
        penable  <= 1'b0;
        wait_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed vector table, hand-written corner sequences, random traffic.
// Latency: transfers are expected to finish 3 + wait-state cycles after acceptance.
// Backpressure: slave model inserts programmable wait states or holds PREADY low.
module tb_apb_master;

  localparam int TO = 16;

  logic PCLK;
  logic PRESETn;

  apb_master_if bus ();

  apb_master #(.TIMEOUT(TO)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int errors = 0;
  int checks = 0;

  // Slave environment: one address space, slave 2 owns addresses with bit 7 set.
  int         slv_waits = 0;
  bit         slv_stuck = 0;
  int         acc = 0;
  bit [7:0]   smem [256];
  bit         swr  [256];
  logic [7:0] srd;
  logic       tb_rdy;

  function automatic logic [7:0] init_val(input logic [7:0] a);
    if (a == 8'h85) return 8'h3C;
    return a * 8'd7 + 8'd1;
  endfunction

  always_comb srd = swr[bus.PADDR] ? smem[bus.PADDR] : init_val(bus.PADDR);

  assign bus.PRDATA1 = bus.PSEL1 ? srd : 8'hFF;
  assign bus.PRDATA2 = bus.PSEL2 ? srd : 8'hFF;
  assign bus.PREADY1 = bus.PSEL1 ? (bus.PENABLE && !slv_stuck && acc >= slv_waits) : 1'b1;
  assign bus.PREADY2 = bus.PSEL2 ? (bus.PENABLE && !slv_stuck && acc >= slv_waits) : 1'b1;
  assign tb_rdy      = bus.PADDR[7] ? bus.PREADY2 : bus.PREADY1;

  always @(posedge PCLK) begin
    if (bus.PENABLE && !tb_rdy) acc <= acc + 1;
    else acc <= 0;
    if (bus.PENABLE && tb_rdy && bus.PWRITE) begin
      smem[bus.PADDR] <= bus.PWDATA;
      swr[bus.PADDR]  <= 1'b1;
    end
  end

  // Reference model: what the host should observe, from the transfer rules alone.
  bit [7:0]   mod_mem [256];
  bit         mod_wr  [256];
  logic [7:0] rdata_m = 8'h00;

  task automatic predict(input logic w, input logic [7:0] a, input logic [7:0] d,
                         input int nw, input bit stk,
                         output int lat, output logic e, output logic [7:0] rd);
    if (stk) begin
      lat = 2 + TO;
      e   = 1'b1;
    end else begin
      lat = 3 + nw;
      e   = 1'b0;
      if (w) begin
        mod_mem[a] = d;
        mod_wr[a]  = 1'b1;
      end else begin
        rdata_m = mod_wr[a] ? mod_mem[a] : init_val(a);
      end
    end
    rd = rdata_m;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One complete transfer from the host side, checking bus phases every cycle.
  task automatic xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                      input int nw, input bit stk,
                      output int lat, output logic e, output logic [7:0] rd);
    int guard;
    logic [19:0] exp_bus;
    slv_waits = nw;
    slv_stuck = stk;
    guard = 0;
    while (!bus.host_ready && guard < 50) begin
      @(negedge PCLK);
      guard++;
    end
    check("ready_before_req", {31'd0, bus.host_ready}, 32'd1);
    bus.host_req   = 1'b1;
    bus.host_write = w;
    bus.host_addr  = a;
    bus.host_wdata = d;
    @(negedge PCLK);
    bus.host_req   = 1'b0;
    bus.host_write = 1'($urandom);
    bus.host_addr  = 8'($urandom);
    bus.host_wdata = 8'($urandom);
    lat = 1;
    exp_bus = {~a[7], a[7], 1'b0, w, a, d};
    check("setup_phase", {12'd0, bus.PSEL1, bus.PSEL2, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA},
          {12'd0, exp_bus});
    check("ready_in_setup", {31'd0, bus.host_ready}, 32'd0);
    exp_bus = {~a[7], a[7], 1'b1, w, a, d};
    while (!bus.host_done && lat < 40) begin
      @(negedge PCLK);
      lat++;
      if (!bus.host_done)
        check("access_phase", {12'd0, bus.PSEL1, bus.PSEL2, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA},
              {12'd0, exp_bus});
    end
    e  = bus.host_err;
    rd = bus.host_rdata;
    check("idle_after_done", {29'd0, bus.PSEL1, bus.PSEL2, bus.PENABLE}, 32'd0);
    check("ready_after_done", {31'd0, bus.host_ready}, 32'd1);
    @(negedge PCLK);
    check("done_single_pulse", {31'd0, bus.host_done}, 32'd0);
  endtask

  typedef struct {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    int         nw;
    bit         stk;
    int         lat;
    logic       err;
    logic [7:0] rd;
  } vec_t;

  vec_t vecs [9];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running at time limit, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int         lat, plat;
    logic       e, pe;
    logic [7:0] rd, prd;
    int         dcnt;

    bus.host_req   = 1'b0;
    bus.host_write = 1'b0;
    bus.host_addr  = 8'h00;
    bus.host_wdata = 8'h00;
    PRESETn        = 1'b0;

    // Reset state
    repeat (2) @(negedge PCLK);
    check("reset_outputs", {8'd0, bus.PSEL1, bus.PSEL2, bus.PENABLE, bus.PWRITE, bus.host_done, bus.host_err,
                            bus.PADDR, bus.PWDATA, bus.host_rdata}, 32'd0);
    check("reset_ready", {31'd0, bus.host_ready}, 32'd1);
    PRESETn = 1'b1;
    @(negedge PCLK);

    // Directed table: w, addr, wdata, waits, stuck -> latency, err, rdata
    vecs[0] = '{1'b1, 8'h05, 8'hA5, 0, 1'b0,  3, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 8'h85, 8'h00, 0, 1'b0,  3, 1'b0, 8'h3C};
    vecs[2] = '{1'b0, 8'h05, 8'h00, 0, 1'b0,  3, 1'b0, 8'hA5};
    vecs[3] = '{1'b1, 8'h10, 8'h5A, 3, 1'b0,  6, 1'b0, 8'hA5};
    vecs[4] = '{1'b0, 8'h10, 8'h00, 1, 1'b0,  4, 1'b0, 8'h5A};
    vecs[5] = '{1'b1, 8'h90, 8'h77, 2, 1'b0,  5, 1'b0, 8'h5A};
    vecs[6] = '{1'b0, 8'h90, 8'h00, 0, 1'b0,  3, 1'b0, 8'h77};
    vecs[7] = '{1'b0, 8'h85, 8'h00, 0, 1'b1, 18, 1'b1, 8'h77};
    vecs[8] = '{1'b0, 8'h20, 8'h00, 0, 1'b0,  3, 1'b0, 8'hE1};

    for (int i = 0; i < 9; i++) begin
      xfer(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].nw, vecs[i].stk, lat, e, rd);
      predict(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].nw, vecs[i].stk, plat, pe, prd);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].err});
      check($sformatf("vec%0d_rdata", i), {24'd0, rd}, {24'd0, vecs[i].rd});
    end

    // Back-to-back writes with host_req held high
    slv_waits = 0;
    slv_stuck = 0;
    bus.host_req   = 1'b1;
    bus.host_write = 1'b1;
    bus.host_addr  = 8'h01;
    bus.host_wdata = 8'h11;
    @(negedge PCLK);
    check("b2b_setup1", {22'd0, bus.PSEL1, bus.PENABLE, bus.PADDR}, {22'd0, 2'b10, 8'h01});
    bus.host_addr  = 8'h02;
    bus.host_wdata = 8'h22;
    @(negedge PCLK);
    check("b2b_access1", {22'd0, bus.PSEL1, bus.PENABLE, bus.PADDR}, {22'd0, 2'b11, 8'h01});
    check("b2b_ready_access1", {31'd0, bus.host_ready}, 32'd1);
    @(negedge PCLK);
    check("b2b_setup2_no_idle", {21'd0, bus.host_done, bus.PSEL1, bus.PENABLE, bus.PADDR},
          {21'd0, 3'b110, 8'h02});
    bus.host_req = 1'b0;
    @(negedge PCLK);
    check("b2b_access2", {21'd0, bus.host_done, bus.PSEL1, bus.PENABLE, bus.PADDR},
          {21'd0, 3'b011, 8'h02});
    @(negedge PCLK);
    check("b2b_done2", {29'd0, bus.host_done, bus.PSEL1, bus.PENABLE}, {29'd0, 3'b100});
    predict(1'b1, 8'h01, 8'h11, 0, 1'b0, plat, pe, prd);
    predict(1'b1, 8'h02, 8'h22, 0, 1'b0, plat, pe, prd);
    @(negedge PCLK);
    xfer(1'b0, 8'h02, 8'h00, 0, 1'b0, lat, e, rd);
    predict(1'b0, 8'h02, 8'h00, 0, 1'b0, plat, pe, prd);
    check("b2b_readback", {24'd0, rd}, 32'h22);

    // Random traffic against the model
    for (int i = 0; i < 40; i++) begin
      logic       w;
      logic [7:0] a, d;
      int         nw;
      bit         stk;
      w   = 1'($urandom_range(0, 1));
      a   = 8'($urandom);
      d   = 8'($urandom);
      nw  = int'($urandom_range(0, 3));
      stk = ($urandom_range(0, 9) == 0);
      predict(w, a, d, nw, stk, plat, pe, prd);
      xfer(w, a, d, nw, stk, lat, e, rd);
      check($sformatf("rnd%0d_latency", i), lat, plat);
      check($sformatf("rnd%0d_err", i), {31'd0, e}, {31'd0, pe});
      check($sformatf("rnd%0d_rdata", i), {24'd0, rd}, {24'd0, prd});
    end

    // Reset asserted in the middle of an ACCESS phase
    slv_waits = 0;
    slv_stuck = 1;
    bus.host_req   = 1'b1;
    bus.host_write = 1'b1;
    bus.host_addr  = 8'h33;
    bus.host_wdata = 8'h44;
    @(negedge PCLK);
    bus.host_req = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    check("rst_mid_in_access", {31'd0, bus.PENABLE}, 32'd1);
    #1 PRESETn = 1'b0;
    #1;
    check("rst_mid_outputs", {8'd0, bus.PSEL1, bus.PSEL2, bus.PENABLE, bus.PWRITE, bus.host_done, bus.host_err,
                              bus.PADDR, bus.PWDATA, bus.host_rdata}, 32'd0);
    check("rst_mid_ready", {31'd0, bus.host_ready}, 32'd1);
    @(negedge PCLK);
    PRESETn   = 1'b1;
    slv_stuck = 0;
    rdata_m   = 8'h00;
    dcnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      if (bus.host_done) dcnt++;
    end
    check("rst_mid_no_done", dcnt, 0);
    predict(1'b0, 8'h33, 8'h00, 0, 1'b0, plat, pe, prd);
    xfer(1'b0, 8'h33, 8'h00, 0, 1'b0, lat, e, rd);
    check("post_rst_latency", lat, plat);
    check("post_rst_rdata", {24'd0, rd}, {24'd0, prd});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
